// File: rtl/stream_switch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_switch_sequencer_if
// Purpose  : Bundles the select-request handshake and the switch ingress
//            monitor taps seen by stream_switch_sequencer.
// Signals  : req_valid/req_select/req_ready - select request handshake
//            axis_tvalid/axis_tready/axis_tlast - ingress beat monitor taps
//            (axis_tready is the post-gate ready actually seen by the switch)
// Modports : master - request source / integrator side
//            slave  - sequencer side
// Revision : 1.0 - initial release
// ============================================================================
interface stream_switch_sequencer_if #(
    parameter int CL_M_COUNT = 1
);
    logic                  req_valid;
    logic [CL_M_COUNT-1:0] req_select;
    logic                  req_ready;
    logic                  axis_tvalid;
    logic                  axis_tready;
    logic                  axis_tlast;

    modport master (
        output req_valid,
        output req_select,
        input  req_ready,
        output axis_tvalid,
        output axis_tready,
        output axis_tlast
    );

    modport slave (
        input  req_valid,
        input  req_select,
        output req_ready,
        input  axis_tvalid,
        input  axis_tready,
        input  axis_tlast
    );
endinterface
`default_nettype wire

// File: rtl/stream_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stream_switch_sequencer
// Purpose  : Applies a new demux output select only on a packet boundary and
//            after the datapath has drained. While a request is in flight the
//            gate output asks the integrator to hold ingress tready low at the
//            start of a new packet; a packet already in progress is never
//            stalled. Invalid selects and wait timeouts abort the request.
// Ports    : axil_aclk     - clock
//            axil_aresetn  - asynchronous active-low reset
//            ctl           - request handshake + ingress monitor (slave)
//            gate          - 1 = hold ingress tready low at packet start
//            select_active - select driven into the demux
//            busy          - a request is in flight
//            done          - one-cycle completion pulse
//            done_ok       - qualifies done: 1 = applied, 0 = aborted
//            timeout_err   - sticky wait-for-end-of-packet timeout flag
//            err_clear     - clears timeout_err (a same-cycle set wins)
//            switch_count  - applied switches, wraps at 2^16
// Notes    : M_COUNT must be >= 2, DRAIN_CYCLES in 0..255,
//            TIMEOUT_CYCLES in 0..65535 (0 disables the timeout).
// Revision : 1.0 - initial release
// ============================================================================
module stream_switch_sequencer #(
    parameter int M_COUNT        = 2,
    parameter int CL_M_COUNT     = $clog2(M_COUNT),
    parameter int DRAIN_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int RESET_SELECT   = 0
) (
    input  wire logic                  axil_aclk,
    input  wire logic                  axil_aresetn,
    stream_switch_sequencer_if.slave   ctl,
    output logic                       gate,
    output logic [CL_M_COUNT-1:0]      select_active,
    output logic                       busy,
    output logic                       done,
    output logic                       done_ok,
    output logic                       timeout_err,
    input  wire logic                  err_clear,
    output logic [15:0]                switch_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_EOP = 3'd1,
        S_DRAIN    = 3'd2,
        S_APPLY    = 3'd3,
        S_ABORT    = 3'd4
    } state_t;

    localparam logic [CL_M_COUNT-1:0] RESET_SEL    = CL_M_COUNT'(RESET_SELECT);
    localparam bit                    DRAIN_EN     = (DRAIN_CYCLES != 0);
    localparam bit                    TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    // Terminal counter values; the guarded forms keep the constants in range
    // when the corresponding feature is disabled.
    localparam logic [7:0]            DRAIN_LAST   = 8'(DRAIN_EN ? DRAIN_CYCLES - 1 : 0);
    localparam logic [15:0]           TIMEOUT_LAST = 16'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  state;
    state_t                  state_nxt;
    logic [CL_M_COUNT-1:0]   sel_q;
    logic                    in_packet;
    logic [15:0]             wait_cnt;
    logic [7:0]              drain_cnt;

    logic                    beat;
    logic                    eop_beat;
    logic                    accept;
    logic                    req_bad;
    logic                    wait_exit;
    logic                    wait_timeout;

    // ------------------------------------------------------------------
    // Ingress monitor decode
    // ------------------------------------------------------------------
    assign beat     = ctl.axis_tvalid && ctl.axis_tready;
    assign eop_beat = beat && ctl.axis_tlast;

    // Requests are only taken in IDLE; anything presented while busy is
    // simply not acknowledged and therefore never queued.
    assign accept   = ctl.req_valid && (state == S_IDLE);
    assign req_bad  = (int'(ctl.req_select) >= M_COUNT);

    // The link is between packets either when no packet is open or when the
    // closing beat is transferring right now.
    assign wait_exit    = !in_packet || eop_beat;
    assign wait_timeout = TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        ctl.req_ready = 1'b0;
        busy          = 1'b1;
        gate          = 1'b1;

        case (state)
            S_IDLE: begin
                ctl.req_ready = 1'b1;
                busy          = 1'b0;
                gate          = 1'b0;
                if (accept) begin
                    state_nxt = req_bad ? S_ABORT : S_WAIT_EOP;
                end
            end
            S_WAIT_EOP: begin
                // A boundary seen in the same cycle as the timeout wins.
                if (wait_exit) begin
                    state_nxt = DRAIN_EN ? S_DRAIN : S_APPLY;
                end else if (wait_timeout) begin
                    state_nxt = S_ABORT;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                state_nxt = S_IDLE;
            end
            S_ABORT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: packet tracking, counters, select and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            sel_q         <= '0;
            in_packet     <= 1'b0;
            wait_cnt      <= 16'd0;
            drain_cnt     <= 8'd0;
            select_active <= RESET_SEL;
            switch_count  <= 16'd0;
            done          <= 1'b0;
            done_ok       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            done_ok <= 1'b0;

            if (beat) begin
                in_packet <= !ctl.axis_tlast;
            end

            if (accept) begin
                sel_q <= ctl.req_select;
            end

            // Both counters sit at zero outside their own state, so each
            // starts from zero on entry without an explicit load.
            wait_cnt  <= (state == S_WAIT_EOP) ? wait_cnt + 16'd1 : 16'd0;
            drain_cnt <= (state == S_DRAIN)    ? drain_cnt + 8'd1 : 8'd0;

            if (state == S_APPLY) begin
                select_active <= sel_q;
                switch_count  <= switch_count + 16'd1;
                done          <= 1'b1;
                done_ok       <= 1'b1;
            end

            if (state == S_ABORT) begin
                done <= 1'b1;
            end

            if ((state == S_WAIT_EOP) && !wait_exit && wait_timeout) begin
                timeout_err <= 1'b1;
            end else if (err_clear) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_switch_sequencer
// Purpose  : Self-checking bench for stream_switch_sequencer. A schedule-based
//            reference model predicts, for each accepted request, the cycle in
//            which done becomes visible and whether the switch is applied.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_switch_sequencer;

    localparam int M_COUNT      = 3;
    localparam int CL_M_COUNT   = 2;
    localparam int DRAIN        = 2;
    localparam int TIMEOUT      = 16;
    localparam int RESET_SELECT = 0;

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  err_clear = 1'b0;
    logic                  gate;
    logic                  busy;
    logic                  done;
    logic                  done_ok;
    logic                  timeout_err;
    logic [CL_M_COUNT-1:0] select_active;
    logic [15:0]           switch_count;

    stream_switch_sequencer_if #(.CL_M_COUNT(CL_M_COUNT)) sif ();

    stream_switch_sequencer #(
        .M_COUNT        (M_COUNT),
        .CL_M_COUNT     (CL_M_COUNT),
        .DRAIN_CYCLES   (DRAIN),
        .TIMEOUT_CYCLES (TIMEOUT),
        .RESET_SELECT   (RESET_SELECT)
    ) dut (
        .axil_aclk     (clk),
        .axil_aresetn  (rst_n),
        .ctl           (sif),
        .gate          (gate),
        .select_active (select_active),
        .busy          (busy),
        .done          (done),
        .done_ok       (done_ok),
        .timeout_err   (timeout_err),
        .err_clear     (err_clear),
        .switch_count  (switch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: a request in flight is either still waiting for a
    // packet boundary, or has a known completion cycle (done_at).
    int          done_at;
    bit          exp_ok;
    bit          waiting;
    int          wait_n;
    logic [1:0]  held_sel;
    logic [1:0]  m_sel;
    logic [15:0] m_count;
    bit          m_terr;
    bit          m_inpkt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit pending();
        return waiting || (done_at > cyc);
    endfunction

    task automatic model_reset();
        done_at  = -1;
        exp_ok   = 1'b0;
        waiting  = 1'b0;
        wait_n   = 0;
        held_sel = 2'd0;
        m_sel    = 2'(RESET_SELECT);
        m_count  = 16'd0;
        m_terr   = 1'b0;
        m_inpkt  = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_select", 32'(select_active), 32'(RESET_SELECT));
        check("rst_busy",   32'(busy),          32'd0);
        check("rst_gate",   32'(gate),          32'd0);
        check("rst_done",   32'(done),          32'd0);
        check("rst_count",  32'(switch_count),  32'd0);
        check("rst_terr",   32'(timeout_err),   32'd0);
        check("rst_ready",  32'(sif.req_ready), 32'd1);
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    // Entered and left at posedge + 1.
    task automatic cycle(input bit v, input logic [1:0] s, input bit tv,
                         input bit tr_raw, input bit tl, input bit ec);
        bit pend;
        bit beat;
        bit tmo;
        pend = pending();
        sif.req_valid   = v;
        sif.req_select  = s;
        sif.axis_tvalid = tv;
        // Integrator behaviour: no new packet may start while gated.
        sif.axis_tready = tr_raw && !(pend && !m_inpkt);
        sif.axis_tlast  = tl;
        err_clear       = ec;
        #1;
        check("req_ready", 32'(sif.req_ready),   32'(!pend));
        check("gate",      32'(gate),            32'(pend));
        check("busy",      32'(busy),            32'(pend));
        check("done",      32'(done),            32'(cyc == done_at));
        if (cyc == done_at) begin
            check("done_ok", 32'(done_ok), 32'(exp_ok));
        end
        check("select",    32'(select_active),   32'(m_sel));
        check("count",     32'(switch_count),    32'(m_count));
        check("terr",      32'(timeout_err),     32'(m_terr));

        beat = tv && sif.axis_tready;
        tmo  = 1'b0;
        if (pend) begin
            if (waiting) begin
                if (!m_inpkt || (beat && tl)) begin
                    waiting = 1'b0;
                    done_at = cyc + DRAIN + 2;
                    exp_ok  = 1'b1;
                end else begin
                    wait_n++;
                    if (TIMEOUT != 0 && wait_n == TIMEOUT) begin
                        waiting = 1'b0;
                        done_at = cyc + 2;
                        exp_ok  = 1'b0;
                        tmo     = 1'b1;
                    end
                end
            end
        end else if (v) begin
            held_sel = s;
            if (int'(s) >= M_COUNT) begin
                done_at = cyc + 2;
                exp_ok  = 1'b0;
            end else begin
                waiting = 1'b1;
                wait_n  = 0;
            end
        end
        if (tmo) begin
            m_terr = 1'b1;
        end else if (ec) begin
            m_terr = 1'b0;
        end
        if (beat) begin
            m_inpkt = !tl;
        end
        if (done_at == cyc + 1 && exp_ok) begin
            m_sel   = held_sel;
            m_count = m_count + 16'd1;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit long_mode;
        sif.req_valid   = 1'b0;
        sif.req_select  = 2'd0;
        sif.axis_tvalid = 1'b0;
        sif.axis_tready = 1'b0;
        sif.axis_tlast  = 1'b0;
        model_reset();
        long_mode = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;

        // Idle link, switch to port 1: done at cycle 5 after accept.
        cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Reset asserted while draining: immediate return to reset values.
        cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc += 2;
        idle(6);

        // 6-beat packet, request at beat 2; afterwards the source keeps
        // offering single-beat packets which must stay blocked while gated.
        for (int b = 0; b < 6; b++) begin
            cycle(b == 2, 2'd2, 1'b1, 1'b1, b == 5, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        idle(2);

        // Timeout with tlast withheld, once sticky then cleared, once with
        // err_clear held through the timeout (set wins, then clears).
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
            cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 20; i++) begin
                cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, k == 1);
            end
            cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
            idle(2);
        end

        // Out-of-range select aborts without a timeout.
        cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);

        // req_valid held through busy with a changing select.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 2'((i + 1) % 3), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(8);

        // Randomized traffic; some stretches never close their packet.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                long_mode = ($urandom_range(0, 2) == 0);
            end
            cycle($urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0,
                  long_mode ? 1'b0 : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 31) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
